ec_scalar_mult_ctrl: RTL



---
 rtl/ec_scalar_mult_ctrl_if.sv | 22 ++
 rtl/ec_scalar_mult_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ec_scalar_mult_ctrl_if.sv
// ec_scalar_mult_ctrl_if: job, result and point-core handshake bundle for the scalar-multiplication sequencer
// Ports: in_* job request, out_* result strobe, busy, ec_* operand strobe to the core, ec_out_valid/ec_Rx/ec_Ry core result.
// slave is the sequencer side; master is the job issuer plus point core side.
interface ec_scalar_mult_ctrl_if #(parameter int W = 6, parameter int K_W = 6);
  logic in_valid;
  logic [W-1:0] in_Px, in_Py, in_prime, in_a;
  logic [K_W-1:0] in_k;
  logic out_valid, out_inf, busy;
  logic [W-1:0] out_Rx, out_Ry;
  logic ec_in_valid, ec_out_valid;
  logic [W-1:0] ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a, ec_Rx, ec_Ry;
  modport slave (
    input in_valid, in_Px, in_Py, in_k, in_prime, in_a, ec_out_valid, ec_Rx, ec_Ry,
    output out_valid, out_Rx, out_Ry, out_inf, busy,
    output ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a
  );
  modport master (
    output in_valid, in_Px, in_Py, in_k, in_prime, in_a, ec_out_valid, ec_Rx, ec_Ry,
    input out_valid, out_Rx, out_Ry, out_inf, busy,
    input ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a
  );
endinterface

// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: left-to-right double-and-add sequencer driving an EC point add/double core
// Ports: clk, rst_n (async, active-low), bus (slave modport: job in, result out, core handshake).
// Infinity, P + (-P) and doubling a point with y = 0 are resolved here without calling the core.
module ec_scalar_mult_ctrl #(parameter int W = 6, parameter int K_W = 6) (
  input logic clk,
  input logic rst_n,
  ec_scalar_mult_ctrl_if.slave bus
);
  localparam int IW = K_W > 1 ? $clog2(K_W) : 1;
  localparam logic [2:0] IDLE = 3'd0, DBL = 3'd1, DBL_WAIT = 3'd2, ADD = 3'd3,
                         ADD_WAIT = 3'd4, NEXT = 3'd5, DONE = 3'd6;
  logic [2:0] state;
  logic [W-1:0] px, py, p, a, rx, ry;
  logic [K_W-1:0] k;
  logic [IW-1:0] i;
  logic r_inf;
  logic out_valid, out_inf, ec_in_valid;
  logic [W-1:0] out_rx, out_ry, ec_px, ec_py, ec_qx, ec_qy, ec_prime, ec_a;
  logic [2:0] after_dbl;
  assign after_dbl = k[i] ? ADD : NEXT;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = out_valid;
  assign bus.out_Rx = out_rx;
  assign bus.out_Ry = out_ry;
  assign bus.out_inf = out_inf;
  assign bus.ec_in_valid = ec_in_valid;
  assign bus.ec_Px = ec_px;
  assign bus.ec_Py = ec_py;
  assign bus.ec_Qx = ec_qx;
  assign bus.ec_Qy = ec_qy;
  assign bus.ec_prime = ec_prime;
  assign bus.ec_a = ec_a;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      px <= '0;
      py <= '0;
      p <= '0;
      a <= '0;
      k <= '0;
      i <= '0;
      rx <= '0;
      ry <= '0;
      r_inf <= 1'b1;
      out_valid <= 1'b0;
      out_rx <= '0;
      out_ry <= '0;
      out_inf <= 1'b0;
      ec_in_valid <= 1'b0;
      ec_px <= '0;
      ec_py <= '0;
      ec_qx <= '0;
      ec_qy <= '0;
      ec_prime <= '0;
      ec_a <= '0;
    end else begin
      ec_in_valid <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          px <= bus.in_Px;
          py <= bus.in_Py;
          p <= bus.in_prime;
          a <= bus.in_a;
          k <= bus.in_k;
          i <= IW'(K_W - 1);
          rx <= '0;
          ry <= '0;
          r_inf <= 1'b1;
          state <= DBL;
        end
        DBL: if (r_inf) begin
          state <= after_dbl;
        end else if (ry == '0) begin
          r_inf <= 1'b1;
          state <= after_dbl;
        end else begin
          ec_in_valid <= 1'b1;
          ec_px <= rx;
          ec_py <= ry;
          ec_qx <= rx;
          ec_qy <= ry;
          ec_prime <= p;
          ec_a <= a;
          state <= DBL_WAIT;
        end
        DBL_WAIT: if (bus.ec_out_valid) begin
          rx <= bus.ec_Rx;
          ry <= bus.ec_Ry;
          state <= after_dbl;
        end
        ADD: if (r_inf) begin
          rx <= px;
          ry <= py;
          r_inf <= 1'b0;
          state <= NEXT;
        end else if (rx == px && (ry != py || ry == '0)) begin
          // R = -P gives infinity; R = P with y = 0 doubles to infinity
          r_inf <= 1'b1;
          state <= NEXT;
        end else begin
          // R = P falls through here too: Q = P = R makes this a core doubling
          ec_in_valid <= 1'b1;
          ec_px <= rx;
          ec_py <= ry;
          ec_qx <= px;
          ec_qy <= py;
          ec_prime <= p;
          ec_a <= a;
          state <= ADD_WAIT;
        end
        ADD_WAIT: if (bus.ec_out_valid) begin
          rx <= bus.ec_Rx;
          ry <= bus.ec_Ry;
          state <= NEXT;
        end
        NEXT: if (i == '0) begin
          out_valid <= 1'b1;
          out_rx <= r_inf ? '0 : rx;
          out_ry <= r_inf ? '0 : ry;
          out_inf <= r_inf;
          state <= DONE;
        end else begin
          i <= i - 1'b1;
          state <= DBL;
        end
        DONE: begin
          out_rx <= '0;
          out_ry <= '0;
          out_inf <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
